// File: rtl/up_sampler.sv
// up_sampler
// Reader end of the Gaussian stage output FIFO. Pulls a half-resolution pixel
// stream and emits a 2x nearest-neighbour upsampled stream: each pixel is
// sent twice on the fill pass, then the buffered row is replayed (each pixel
// twice again) so every input row appears as two output rows.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   empty      upstream FIFO empty flag
//   rd_en_up   one-cycle read strobe to the upstream FIFO
//   valid      upstream read data valid (one cycle after rd_en_up)
//   din[7:0]   upstream pixel, qualified by valid
//   valid_out  output pixel valid
//   dout[7:0]  output pixel
//   ready      downstream accept; beat transfers on valid_out & ready
//   out_last   final beat of an output frame, qualified by valid_out
//   frame_done one-cycle pulse after the out_last beat transfers
module up_sampler #(
  parameter int IN_WIDTH  = 40,
  parameter int IN_HEIGHT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  output logic       rd_en_up,
  input  logic       valid,
  input  logic [7:0] din,
  output logic       valid_out,
  output logic [7:0] dout,
  input  logic       ready,
  output logic       out_last,
  output logic       frame_done
);

  localparam int COL_W = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic [1:0] {FETCH, EMIT, REPLAY} state_t;

  state_t           state, state_n;
  logic [7:0]       linebuf [IN_WIDTH];
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic             dup, dup_n;
  logic             pending, pending_n;
  logic             valid_out_n, out_last_n, frame_done_n;
  logic [7:0]       dout_n;
  logic             rd_req, buf_we;
  logic             xfer, col_end, row_end;

  assign xfer     = valid_out & ready;
  assign col_end  = (col == COL_MAX);
  assign row_end  = (row == ROW_MAX);
  // The combinational request is masked during reset so the strobe reads 0
  // while rst is held.
  assign rd_en_up = rd_req & ~rst;

  always_comb begin
    state_n      = state;
    col_n        = col;
    row_n        = row;
    dup_n        = dup;
    pending_n    = pending;
    valid_out_n  = valid_out;
    dout_n       = dout;
    out_last_n   = out_last;
    frame_done_n = xfer & out_last;
    rd_req       = 1'b0;
    buf_we       = 1'b0;

    case (state)
      FETCH: begin
        if (pending) begin
          if (valid) begin
            buf_we      = 1'b1;
            dout_n      = din;
            valid_out_n = 1'b1;
            pending_n   = 1'b0;
            state_n     = EMIT;
          end
        end else if (!empty) begin
          rd_req    = 1'b1;
          pending_n = 1'b1;
        end
      end

      EMIT: begin
        if (xfer) begin
          if (!dup) begin
            dup_n = 1'b1;
          end else begin
            dup_n = 1'b0;
            if (col_end) begin
              // Preload the first replay pixel so replay starts without a gap.
              col_n   = '0;
              state_n = REPLAY;
              dout_n  = linebuf[col_n];
            end else begin
              col_n       = col + 1'b1;
              valid_out_n = 1'b0;
              state_n     = FETCH;
              // Overlap the next read with the second copy's transfer.
              if (!empty && !pending) begin
                rd_req    = 1'b1;
                pending_n = 1'b1;
              end
            end
          end
        end
      end

      REPLAY: begin
        if (xfer) begin
          if (!dup) begin
            dup_n = 1'b1;
            // The next beat is the last one of the frame.
            if (col_end && row_end) out_last_n = 1'b1;
          end else begin
            dup_n = 1'b0;
            if (col_end) begin
              col_n       = '0;
              row_n       = row_end ? '0 : row + 1'b1;
              valid_out_n = 1'b0;
              out_last_n  = 1'b0;
              state_n     = FETCH;
              if (!empty && !pending) begin
                rd_req    = 1'b1;
                pending_n = 1'b1;
              end
            end else begin
              // Look one column ahead so back-to-back replay beats never stall.
              col_n  = col + 1'b1;
              dout_n = linebuf[col_n];
            end
          end
        end
      end

      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      col        <= '0;
      row        <= '0;
      dup        <= 1'b0;
      pending    <= 1'b0;
      valid_out  <= 1'b0;
      dout       <= 8'd0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      dup        <= dup_n;
      pending    <= pending_n;
      valid_out  <= valid_out_n;
      dout       <= dout_n;
      out_last   <= out_last_n;
      frame_done <= frame_done_n;
    end
  end

  // Line buffer holds data only; its contents survive reset.
  always_ff @(posedge clk) begin
    if (buf_we) linebuf[col] <= din;
  end

endmodule

// File: tb/tb_up_sampler.sv
// Bench for up_sampler with IN_WIDTH=4, IN_HEIGHT=2. A behavioural FIFO
// answers rd_en_up one cycle later; a monitor compares output beats against
// a queue of expected {last, pixel} values.
module tb_up_sampler;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk, rst, empty, rd_en_up, valid, valid_out, ready, out_last, frame_done;
  logic [7:0] din, dout;

  up_sampler #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .empty(empty), .rd_en_up(rd_en_up), .valid(valid),
    .din(din), .valid_out(valid_out), .dout(dout), .ready(ready),
    .out_last(out_last), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  logic       spur = 1'b0;
  logic       flush = 1'b0;
  logic       mon_en = 1'b0;
  logic       rand_rdy = 1'b0;
  int         beats = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Upstream FIFO model: data appears one cycle after the strobe.
  initial begin : fifo_model
    logic fire, sp;
    valid = 1'b0;
    din   = 8'd0;
    empty = 1'b1;
    forever begin
      @(negedge clk);
      fire = rd_en_up && !empty;
      sp   = spur;
      @(posedge clk);
      #1;
      if (flush) begin
        valid = 1'b0;
        fifo_q.delete();
        flush = 1'b0;
      end else if (fire) begin
        valid = 1'b1;
        din   = fifo_q.pop_front();
      end else if (sp) begin
        valid = 1'b1;
        din   = 8'hFF;
      end else begin
        valid = 1'b0;
      end
      #1;
      empty = (fifo_q.size() == 0);
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor: beat data, out_last, frame_done timing, stall hold.
  initial begin : monitor
    logic       stalled, last_prev;
    logic [7:0] stall_d;
    logic [8:0] e;
    stalled   = 1'b0;
    last_prev = 1'b0;
    stall_d   = 8'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (stalled)
          check(valid_out && dout == stall_d, "stall_hold", {valid_out, dout}, {1'b1, stall_d});
        check(frame_done == last_prev, "frame_done", frame_done, last_prev);
        if (valid_out && ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            check(1'b0, "extra_beat", {out_last, dout}, 0);
          end else begin
            e = exp_q.pop_front();
            check({out_last, dout} == e, "beat", {out_last, dout}, e);
          end
        end
        last_prev = valid_out && ready && out_last;
        stalled   = valid_out && !ready;
        stall_d   = dout;
      end else begin
        stalled   = 1'b0;
        last_prev = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst   = 1'b1;
    flush = 1'b1;
    spur  = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check(valid_out == 1'b0,  "rst_valid_out",  valid_out,  0);
    check(dout == 8'd0,       "rst_dout",       dout,       0);
    check(out_last == 1'b0,   "rst_out_last",   out_last,   0);
    check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
    check(rd_en_up == 1'b0,   "rst_rd_en_up",   rd_en_up,   0);
  endtask

  // Push nf frames of pixels base, base+1, ... and the expected output beats.
  task automatic push_frames(input int nf, input logic [7:0] base);
    logic [7:0] p;
    @(negedge clk);
    #1;
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < W * H; k++) fifo_q.push_back(8'(base + f * W * H + k));
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < H; r++)
        for (int rep = 0; rep < 2; rep++)
          for (int c = 0; c < W; c++)
            for (int d = 0; d < 2; d++) begin
              p = 8'(base + f * W * H + r * W + c);
              exp_q.push_back({(r == H - 1 && rep == 1 && c == W - 1 && d == 1), p});
            end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, name, exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       push;
    logic [7:0] pval;
    logic       rdy;
    logic       sp;
    logic       e_rd;
    logic       e_vo;
    logic       chk_d;
    logic [7:0] e_d;
  } vec_t;

  localparam int NV = 45;
  vec_t tbl[NV];

  task automatic set_exp(input int i, input logic rd, input logic vo, input logic [7:0] d);
    tbl[i].e_rd  = rd;
    tbl[i].e_vo  = vo;
    tbl[i].chk_d = vo;
    tbl[i].e_d   = d;
  endtask

  initial begin
    int n;
    logic ok;
    rst   = 1'b1;
    ready = 1'b1;

    // Cycle table, cycle 0 = first cycle after reset release.
    for (int i = 0; i < NV; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[0].push = 1'b1;  tbl[0].pval = 8'h11;
    set_exp(0, 1, 0, 8'h00);
    set_exp(2, 0, 1, 8'h11);
    tbl[3].push = 1'b1;  tbl[3].pval = 8'h5A;
    set_exp(3, 1, 1, 8'h11);            // read overlaps second-copy transfer
    set_exp(5, 0, 1, 8'h5A);
    tbl[6].rdy = 1'b0;   set_exp(6, 0, 1, 8'h5A);
    tbl[7].rdy = 1'b0;   set_exp(7, 0, 1, 8'h5A);
    set_exp(8, 0, 1, 8'h5A);
    tbl[8].sp = 1'b1;                   // spurious 0xFF arrives in cycle 9
    tbl[29].push = 1'b1; tbl[29].pval = 8'h33;   // empty for cycles 9..28
    set_exp(29, 1, 0, 8'h00);
    set_exp(31, 0, 1, 8'h33);
    tbl[32].push = 1'b1; tbl[32].pval = 8'h44;
    set_exp(32, 1, 1, 8'h33);
    set_exp(34, 0, 1, 8'h44);
    set_exp(35, 0, 1, 8'h44);
    set_exp(36, 0, 1, 8'h11); set_exp(37, 0, 1, 8'h11);
    set_exp(38, 0, 1, 8'h5A); set_exp(39, 0, 1, 8'h5A);
    set_exp(40, 0, 1, 8'h33); set_exp(41, 0, 1, 8'h33);
    set_exp(42, 0, 1, 8'h44); set_exp(43, 0, 1, 8'h44);

    repeat (2) @(posedge clk);
    do_reset();
    check_reset_vals();

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      if (tbl[i].push) fifo_q.push_back(tbl[i].pval);
      ready = tbl[i].rdy;
      spur  = tbl[i].sp;
      @(negedge clk);
      ok = (rd_en_up == tbl[i].e_rd) && (valid_out == tbl[i].e_vo) &&
           (!tbl[i].chk_d || dout == tbl[i].e_d) && (out_last == 1'b0);
      check(ok, $sformatf("cycle_%0d", i), {out_last, rd_en_up, valid_out, dout},
            {1'b0, tbl[i].e_rd, tbl[i].e_vo, tbl[i].e_d});
    end

    // Full frame 1..8, FIFO never empty, ready high.
    do_reset();
    check_reset_vals();
    mon_en = 1'b1;
    beats  = 0;
    push_frames(1, 8'h01);
    drain("frame_drain");
    check(beats == 4 * W * H, "frame_beats", beats, 4 * W * H);

    // Reset during the replay of row 0, then two clean frames with random stalls.
    beats = 0;
    push_frames(1, 8'h40);
    n = 0;
    while (beats < W * 2 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(beats >= W * 2 + 2, "reach_replay", beats, W * 2 + 2);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    do_reset();
    check_reset_vals();
    mon_en   = 1'b1;
    beats    = 0;
    rand_rdy = 1'b1;
    push_frames(2, 8'h80);
    drain("post_reset_drain");
    rand_rdy = 1'b0;
    ready    = 1'b1;
    check(beats == 8 * W * H, "post_reset_beats", beats, 8 * W * H);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
